// File: rtl/metronome_swing_gen_pkg.sv
// rtl/metronome_swing_gen_pkg.sv - shared FSM encoding and default constants for the metronome swing generator
package metronome_swing_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // One degree in a 32-bit binary angle (2^32 = 360 deg)
    localparam logic [31:0] DEG_1       = 32'h00B60B60;
    localparam int          PHASE_W_DEF = 40;

endpackage

// File: rtl/metronome_swing_gen_tempo_band_scanner.sv
// rtl/metronome_swing_gen_tempo_band_scanner.sv - sequential tempo band search, one threshold per cycle
module metronome_swing_gen_tempo_band_scanner #(
    parameter int  TEMPO_W   = 10,
    parameter int  TEMPO_MIN = 59,
    parameter int  TEMPO_MAX = 240,
    parameter int  NUM_BANDS = 16,
    localparam int BAND_W    = $clog2(NUM_BANDS)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [TEMPO_W-1:0] i_tempo_c,
    input  logic               i_start,
    output logic [BAND_W-1:0]  o_band,
    output logic               o_done
);

    function automatic logic [TEMPO_W-1:0] thr(input int i);
        return TEMPO_W'(TEMPO_MIN + ((TEMPO_MAX - TEMPO_MIN) * i) / NUM_BANDS);
    endfunction

    logic [TEMPO_W-1:0] w_thr [NUM_BANDS];
    for (genvar g = 0; g < NUM_BANDS; g++) begin : g_thr
        assign w_thr[g] = thr(g);
    end

    logic [BAND_W-1:0] r_idx;
    logic [BAND_W-1:0] r_band;
    logic              r_busy;
    logic              w_pass;
    logic              w_last;

    assign w_pass = (i_tempo_c >= w_thr[r_idx]);
    assign w_last = (r_idx == BAND_W'(NUM_BANDS - 1));
    assign o_done = r_busy && (!w_pass || w_last);
    // The result is visible combinationally in the finishing cycle
    assign o_band = (r_busy && w_pass) ? r_idx : r_band;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx  <= BAND_W'(1);
            r_band <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_idx  <= BAND_W'(1);
            r_band <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (w_pass) begin
                r_band <= r_idx;
            end
            if (o_done) begin
                r_busy <= 1'b0;
            end else begin
                r_idx <= r_idx + BAND_W'(1);
            end
        end
    end

endmodule

// File: rtl/metronome_swing_gen.sv
// rtl/metronome_swing_gen.sv - beat-synchronous metronome pendulum angle from a BPM tempo
module metronome_swing_gen
    import metronome_swing_gen_pkg::*;
#(
    parameter int                 TEMPO_W     = 10,
    parameter int                 TEMPO_MIN   = 59,
    parameter int                 TEMPO_MAX   = 240,
    parameter int                 NUM_BANDS   = 16,
    parameter int                 ANGLE_W     = 32,
    parameter logic [ANGLE_W-1:0] DEG_STEP    = ANGLE_W'(DEG_1),
    parameter int                 PHASE_W     = PHASE_W_DEF,
    parameter int                 INC_PER_BPM = 141,
    localparam int                BAND_W      = $clog2(NUM_BANDS)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [TEMPO_W-1:0] i_tempo,
    input  logic               i_frame_strobe,
    output logic [ANGLE_W-1:0] o_angle,
    output logic [ANGLE_W-1:0] o_angle_frame,
    output logic               o_frame_valid,
    output logic               o_beat,
    output logic [BAND_W-1:0]  o_band
);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_start;
    logic               w_scan_done;
    logic [TEMPO_W-1:0] w_tempo_c;
    logic [TEMPO_W-1:0] r_tempo_lat;
    logic               w_stop;
    logic               w_changed;
    logic [BAND_W-1:0]  w_sc_band;
    logic               w_sc_done;

    assign w_tempo_c = (i_tempo > TEMPO_W'(TEMPO_MAX)) ? TEMPO_W'(TEMPO_MAX) : i_tempo;
    assign w_stop    = (i_tempo == '0);
    assign w_changed = (i_tempo != r_tempo_lat);

    metronome_swing_gen_tempo_band_scanner #(
        .TEMPO_W   (TEMPO_W),
        .TEMPO_MIN (TEMPO_MIN),
        .TEMPO_MAX (TEMPO_MAX),
        .NUM_BANDS (NUM_BANDS)
    ) u_scanner (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_tempo_c (w_tempo_c),
        .i_start   (w_start),
        .o_band    (w_sc_band),
        .o_done    (w_sc_done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_scan_done  = 1'b0;
        if (w_stop) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_SCAN;
                    w_start      = 1'b1;
                end
                ST_SCAN: begin
                    if (w_changed) begin
                        w_start = 1'b1;
                    end else if (w_sc_done) begin
                        w_state_next = ST_RUN;
                        w_scan_done  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_changed) begin
                        w_state_next = ST_SCAN;
                        w_start      = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_inc;
    logic [PHASE_W-1:0] w_phase_next;
    logic [ANGLE_W-1:0] r_amp;
    logic [ANGLE_W-1:0] r_amp_pend;
    logic [ANGLE_W-1:0] w_amp_new;
    logic [BAND_W-1:0]  r_band;
    logic               r_first;
    logic               r_beat;
    logic               w_zero_x;
    logic [1:0]         w_q_cur;
    logic [1:0]         w_q_nxt;

    assign w_phase_next = r_phase + r_inc;
    assign w_amp_new    = (ANGLE_W'(w_sc_band) + ANGLE_W'(1)) * DEG_STEP;
    assign w_zero_x     = w_phase_next[PHASE_W-1] ^ r_phase[PHASE_W-1];
    assign w_q_cur      = r_phase[PHASE_W-1 -: 2];
    assign w_q_nxt      = w_phase_next[PHASE_W-1 -: 2];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tempo_lat <= '0;
            r_phase     <= '0;
            r_inc       <= '0;
            r_amp       <= '0;
            r_amp_pend  <= '0;
            r_band      <= '0;
            r_first     <= 1'b1;
            r_beat      <= 1'b0;
        end else begin
            if (w_start) begin
                r_tempo_lat <= i_tempo;
            end
            if (r_state == ST_IDLE) begin
                r_first <= 1'b1;
            end else if (w_scan_done) begin
                r_first <= 1'b0;
            end
            r_beat <= !w_stop && (((w_q_cur == 2'd0) && (w_q_nxt == 2'd1)) ||
                                  ((w_q_cur == 2'd2) && (w_q_nxt == 2'd3)));
            if (w_stop) begin
                r_phase    <= '0;
                r_inc      <= '0;
                r_amp      <= '0;
                r_amp_pend <= '0;
            end else begin
                r_phase <= w_phase_next;
                if (w_scan_done) begin
                    r_inc      <= PHASE_W'(w_tempo_c) * PHASE_W'(INC_PER_BPM);
                    r_amp_pend <= w_amp_new;
                    r_band     <= w_sc_band;
                end
                // Amplitude only moves at a zero crossing so the angle never jumps
                if (w_scan_done && r_first) begin
                    r_amp <= w_amp_new;
                end else if (w_zero_x) begin
                    r_amp <= r_amp_pend;
                end
            end
        end
    end

    logic [15:0]          r_mag;
    logic                 r_sign1;
    logic                 r_sign2;
    logic [ANGLE_W-1:0]   r_scaled;
    logic [ANGLE_W-1:0]   r_angle;
    logic [ANGLE_W+15:0]  w_prod;
    logic [15:0]          w_f;
    logic [ANGLE_W-1:0]   r_angle_frame;
    logic                 r_frame_valid;

    assign w_f    = r_phase[PHASE_W-3 -: 16];
    assign w_prod = (ANGLE_W+16)'(r_amp) * (ANGLE_W+16)'(r_mag);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mag         <= '0;
            r_sign1       <= 1'b0;
            r_sign2       <= 1'b0;
            r_scaled      <= '0;
            r_angle       <= '0;
            r_angle_frame <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_mag         <= w_q_cur[0] ? ~w_f : w_f;
            r_sign1       <= w_q_cur[1];
            r_scaled      <= ANGLE_W'(w_prod >> 16);
            r_sign2       <= r_sign1;
            r_angle       <= r_sign2 ? -r_scaled : r_scaled;
            r_frame_valid <= i_frame_strobe;
            if (i_frame_strobe) begin
                r_angle_frame <= r_angle;
            end
        end
    end

    assign o_angle       = r_angle;
    assign o_angle_frame = r_angle_frame;
    assign o_frame_valid = r_frame_valid;
    assign o_beat        = r_beat;
    assign o_band        = r_band;

endmodule

// File: tb/tb_metronome_swing_gen.sv
// tb/tb_metronome_swing_gen.sv - self-checking bench for metronome_swing_gen
module tb_metronome_swing_gen;

    localparam int     INC = 1 << 22;
    localparam longint DEG = 64'h00B60B60;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  tempo;
    logic        frame_strobe;
    logic [31:0] angle;
    logic [31:0] angle_frame;
    logic        frame_valid;
    logic        beat;
    logic [3:0]  band;

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    longint max_pos, max_neg, max_jump, prev;
    int     n_beats, n_fv;
    int     beat_t[$];
    logic [31:0] a1, a2;
    int     exp_gap;
    int     k;
    int     t;
    int     bnd_t[12] = '{1, 58, 59, 69, 70, 126, 227, 228, 229, 230, 240, 241};

    always #5 clk = ~clk;

    metronome_swing_gen #(.INC_PER_BPM(INC)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_tempo        (tempo),
        .i_frame_strobe (frame_strobe),
        .o_angle        (angle),
        .o_angle_frame  (angle_frame),
        .o_frame_valid  (frame_valid),
        .o_beat         (beat),
        .o_band         (band)
    );

    function automatic int clamp(input int tv);
        return (tv > 240) ? 240 : tv;
    endfunction

    function automatic int model_band(input int tv);
        int b = 0;
        for (int i = 0; i < 16; i++)
            if (clamp(tv) >= 59 + (181 * i) / 16) b = i;
        return b;
    endfunction

    function automatic longint model_amp(input int tv);
        return longint'(model_band(tv) + 1) * DEG;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input longint obs, input longint lo, input longint hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s observed=%0d required=[%0d,%0d]", tag, obs, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_obs();
        max_pos = 0; max_neg = 0; max_jump = 0;
        n_beats = 0; n_fv = 0;
        beat_t.delete();
        prev = longint'($signed(angle));
    endtask

    task automatic observe(input int n);
        longint sa, d;
        for (int i = 0; i < n; i++) begin
            step();
            sa = longint'($signed(angle));
            if (sa > max_pos) max_pos = sa;
            if (-sa > max_neg) max_neg = -sa;
            d = (sa > prev) ? sa - prev : prev - sa;
            if (d > max_jump) max_jump = d;
            prev = sa;
            if (beat) begin n_beats++; beat_t.push_back(cyc); end
            if (frame_valid) n_fv++;
        end
    endtask

    task automatic chk_peak(input string tag, input int tv);
        longint amp = model_amp(tv);
        longint lo = amp - ((amp * longint'(clamp(tv) + 1)) >>> 16) - 2;
        chk_range({tag, "_pos"}, max_pos, lo, amp);
        chk_range({tag, "_neg"}, max_neg, lo, amp);
    endtask

    task automatic wait_beat(input string tag, input int limit);
        int n = 0;
        while (beat !== 1'b1 && n < limit) begin step(); n++; end
        chk_range(tag, n, 0, limit - 1);
    endtask

    initial begin
        reset = 1'b1; tempo = 10'd120; frame_strobe = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_angle", angle, 0);
        chk("reset_beat", beat, 0);
        chk("reset_frame_valid", frame_valid, 0);
        chk("reset_band", band, 0);

        // Band settles after reset release, without a spurious beat
        reset = 1'b0;
        clear_obs();
        k = 0;
        while (band !== 4'(model_band(120)) && k < 16) begin observe(1); k++; end
        chk_range("band120_latency", k, 1, 15);
        chk("band120", band, model_band(120));
        chk("no_beat_on_release", n_beats, 0);

        // Slowest banded tempo
        tempo = 10'd59;
        observe(20);
        chk("band59", band, model_band(59));
        observe(2300);
        clear_obs();
        observe(4500);
        chk_peak("peak59", 59);

        // Clamped tempo, widest swing and beat spacing
        tempo = 10'd1023;
        observe(20);
        chk("band1023", band, model_band(1023));
        observe(1200);
        clear_obs();
        observe(2300);
        chk_peak("peak240", 1023);
        exp_gap = int'((longint'(1) << 39) / (240 * longint'(INC)));
        chk_range("beats240_count", beat_t.size(), 3, 10);
        for (int i = 1; i < beat_t.size(); i++)
            chk_range("beat240_gap", beat_t[i] - beat_t[i-1], exp_gap - 1, exp_gap + 1);

        // Band boundaries, then random tempos
        for (int i = 0; i < 12; i++) begin
            tempo = 10'(bnd_t[i]);
            observe(20);
            chk($sformatf("band_t%0d", bnd_t[i]), band, model_band(bnd_t[i]));
        end
        for (int i = 0; i < 10; i++) begin
            t = int'($urandom_range(1023, 1));
            tempo = 10'(t);
            observe(20);
            chk($sformatf("band_rand_t%0d", t), band, model_band(t));
        end

        // Tempo change at a swing extreme keeps the old amplitude until the zero crossing
        tempo = 10'd120;
        observe(2400);
        wait_beat("beat120_found", 2300);
        tempo = 10'd180;
        clear_obs();
        observe(20);
        chk("band180", band, model_band(180));
        chk_range("amp_held_pos", max_pos, 0, model_amp(120));
        chk_range("amp_held_neg", max_neg, 0, model_amp(120));
        observe(2000);
        chk_range("max_jump", max_jump, 0, 2 * DEG);
        clear_obs();
        observe(1500);
        chk_peak("peak180", 180);

        // Back-to-back frame strobes each take a sample
        observe(100);
        a1 = angle;
        frame_strobe = 1'b1;
        step();
        chk("fv_first", frame_valid, 1);
        chk("af_first", angle_frame, a1);
        a2 = angle;
        step();
        frame_strobe = 1'b0;
        chk("fv_second", frame_valid, 1);
        chk("af_second", angle_frame, a2);
        step();
        chk("fv_drop", frame_valid, 0);

        // Stop mid-swing
        wait_beat("beat180_found", 1500);
        observe(100);
        chk("angle_nonzero_pre_stop", longint'(angle != 32'd0), 1);
        tempo = 10'd0;
        k = 0;
        while (angle !== 32'd0 && k < 4) begin step(); k++; end
        chk_range("stop_to_zero_cycles", k, 1, 4);
        clear_obs();
        observe(60);
        chk("stop_no_beat", n_beats, 0);
        chk("stop_max_pos", max_pos, 0);
        chk("stop_max_neg", max_neg, 0);
        clear_obs();
        frame_strobe = 1'b1;
        observe(1);
        frame_strobe = 1'b0;
        observe(9);
        chk("stop_fv_pulses", n_fv, 1);
        chk("stop_angle_frame", angle_frame, 0);

        // Asynchronous reset mid-scan and mid-swing
        tempo = 10'd200;
        observe(3);
        reset = 1'b1;
        #1;
        chk("rst_scan_band", band, 0);
        chk("rst_scan_angle", angle, 0);
        @(negedge clk);
        reset = 1'b0;
        observe(400);
        chk("band200", band, model_band(200));
        chk("angle_nonzero_pre_reset", longint'(angle != 32'd0), 1);
        reset = 1'b1;
        #1;
        chk("rst_swing_angle", angle, 0);
        chk("rst_swing_band", band, 0);
        chk("rst_swing_beat", beat, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
